// File: rtl/calc_cmd_sequencer_if.sv
// Command handshake between the producer and the calculator command sequencer.
// The producer drives valid/op/data; the sequencer answers with ready.
interface calc_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Queues (op, data) commands for the 8-bit calculator and issues at most one per clock.
// Each READ it issues is followed through the calculator, and the returned value is captured.
module calc_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_cmd_sequencer_if.slave  cmd_if,
  input  logic                 i_pause,
  output logic [2:0]           o_calc_codigo,
  output logic [7:0]           o_calc_entrada,
  input  logic [7:0]           i_calc_saida,
  output logic [7:0]           o_result,
  output logic                 o_result_valid,
  output logic [AW:0]          o_fifo_count
);

  localparam logic [2:0]    OpNop     = 3'b000;
  localparam logic [2:0]    OpRead    = 3'b011;
  localparam logic [AW:0]   FullCount = DEPTH[AW:0];
  localparam logic [AW-1:0] PtrOne    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CountOne  = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
  } cmd_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_calc_codigo;
  logic [7:0]    r_calc_entrada;
  logic [1:0]    r_rd_pipe;
  logic [7:0]    r_result;
  logic          r_result_valid;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  cmd_t          w_head;
  logic [AW:0]   w_count_nxt;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign w_ready = (r_count != FullCount);
  assign w_push  = cmd_if.cmd_valid && w_ready;
  assign w_pop   = !i_pause && (r_count != '0);
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CountOne;
      2'b01:   w_count_nxt = r_count - CountOne;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{op: cmd_if.cmd_op, data: cmd_if.cmd_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      r_count <= w_count_nxt;
    end
  end

  // Paused or empty cycles drive an explicit NOP, so the calculator never sees a stale command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_calc_codigo  <= OpNop;
      r_calc_entrada <= 8'h00;
    end else if (w_pop) begin
      r_calc_codigo  <= w_head.op;
      r_calc_entrada <= w_head.data;
    end else begin
      r_calc_codigo  <= OpNop;
      r_calc_entrada <= 8'h00;
    end
  end

  // The calculator updates saida one edge after it sees READ; capture it one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pipe      <= 2'b00;
      r_result       <= 8'h00;
      r_result_valid <= 1'b0;
    end else begin
      r_rd_pipe <= {r_rd_pipe[0], (w_pop && (w_head.op == OpRead))};
      if (r_rd_pipe[1]) begin
        r_result       <= i_calc_saida;
        r_result_valid <= 1'b1;
      end else begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign cmd_if.cmd_ready = w_ready;
  assign o_calc_codigo    = r_calc_codigo;
  assign o_calc_entrada   = r_calc_entrada;
  assign o_result         = r_result;
  assign o_result_valid   = r_result_valid;
  assign o_fifo_count     = r_count;

  a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= FullCount);
  a_no_full_push : assert property (@(posedge clk) disable iff (rst)
                                    !(cmd_if.cmd_valid && cmd_if.cmd_ready && r_count == FullCount));

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer: it drives vector tables and a few hand-written sequences.
// A small accumulator model stands in for the calculator.
module tb_calc_cmd_sequencer;

  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;
  localparam logic [2:0] RD  = 3'b011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic [2:0] codigo;
  logic [7:0] entrada;
  logic [7:0] saida;
  logic [7:0] result;
  logic       result_valid;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  calc_cmd_sequencer_if cmd_if ();

  calc_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_if         (cmd_if),
    .i_pause        (pause),
    .o_calc_codigo  (codigo),
    .o_calc_entrada (entrada),
    .i_calc_saida   (saida),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Calculator stand-in: an accumulator that presents its value on saida one edge after a READ.
  logic [7:0] acc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= 8'h00;
      saida <= 8'h00;
    end else begin
      case (codigo)
        ADD:     acc   <= acc + entrada;
        SUB:     acc   <= acc - entrada;
        RD:      saida <= acc;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every issued command must match the oldest accepted one.
  logic        sb_en = 1'b0;
  logic [10:0] sb_q[$];
  int          sb_issued = 0;
  always @(posedge clk) begin
    if (sb_en && cmd_if.cmd_valid && cmd_if.cmd_ready)
      sb_q.push_back({cmd_if.cmd_op, cmd_if.cmd_data});
    #1;
    if (sb_en && codigo != 3'b000) begin
      sb_issued++;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("sb_order", int'({codigo, entrada}), int'(sb_q[0]));
        void'(sb_q.pop_front());
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] op;
    logic [7:0] data;
    logic       pause;
    logic       e_ready;
    logic [2:0] e_count;
    logic [2:0] e_codigo;
    logic [7:0] e_entrada;
    logic       e_rv;
    logic [7:0] e_result;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic vl, input logic [2:0] op,
                             input logic [7:0] d, input logic p, input logic er,
                             input logic [2:0] ec, input logic [2:0] eco,
                             input logic [7:0] ee, input logic erv, input logic [7:0] eres);
    vec_t t;
    t.rst = r; t.valid = vl; t.op = op; t.data = d; t.pause = p;
    t.e_ready = er; t.e_count = ec; t.e_codigo = eco; t.e_entrada = ee;
    t.e_rv = erv; t.e_result = eres;
    return t;
  endfunction

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'b000;
    cmd_if.cmd_data  = 8'h00;

    // Reset mid-stream: queued commands, including a READ, must vanish.
    vecs.push_back(v(1, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 1,     1, 1, 1, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, RD,  0,     1, 1, 2, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 3,     1, 1, 3, 0,     0,     0, 0));
    vecs.push_back(v(1, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // ADD 5, ADD 7, SUB 2, READ -> 10
    vecs.push_back(v(1, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 5,     0, 1, 1, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 7,     0, 1, 1, ADD,   5,     0, 0));
    vecs.push_back(v(0, 1, SUB, 2,     0, 1, 1, ADD,   7,     0, 0));
    vecs.push_back(v(0, 1, RD,  0,     0, 1, 1, SUB,   2,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, RD,    0,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     1, 10));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     0, 10));
    // ADD 255, ADD 2, READ -> 1
    vecs.push_back(v(1, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 255,   0, 1, 1, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 2,     0, 1, 1, ADD,   255,   0, 0));
    vecs.push_back(v(0, 1, RD,  0,     0, 1, 1, ADD,   2,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, RD,    0,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     1, 1));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     0, 1));
    // Pause while filling to DEPTH; a fifth push is refused; release drains on 4 edges.
    vecs.push_back(v(1, 0, 0,      0,     0, 1, 0, 0,      0,     0, 0));
    vecs.push_back(v(0, 1, ADD,    1,     1, 1, 1, 0,      0,     0, 0));
    vecs.push_back(v(0, 1, SUB,    2,     1, 1, 2, 0,      0,     0, 0));
    vecs.push_back(v(0, 1, 3'b100, 8'h33, 1, 1, 3, 0,      0,     0, 0));
    vecs.push_back(v(0, 1, 3'b111, 8'h44, 1, 0, 4, 0,      0,     0, 0));
    vecs.push_back(v(0, 1, ADD,    8'h55, 1, 0, 4, 0,      0,     0, 0));
    vecs.push_back(v(0, 0, 0,      0,     0, 1, 3, ADD,    1,     0, 0));
    vecs.push_back(v(0, 0, 0,      0,     0, 1, 2, SUB,    2,     0, 0));
    vecs.push_back(v(0, 0, 0,      0,     0, 1, 1, 3'b100, 8'h33, 0, 0));
    vecs.push_back(v(0, 0, 0,      0,     0, 1, 0, 3'b111, 8'h44, 0, 0));
    vecs.push_back(v(0, 0, 0,      0,     0, 1, 0, 0,      0,     0, 0));
    // ADD 9 then back-to-back READs -> two pulses of 9
    vecs.push_back(v(1, 0, 0,   0,     0, 1, 0, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, ADD, 9,     0, 1, 1, 0,     0,     0, 0));
    vecs.push_back(v(0, 1, RD,  0,     0, 1, 1, ADD,   9,     0, 0));
    vecs.push_back(v(0, 1, RD,  0,     0, 1, 1, RD,    0,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, RD,    0,     0, 0));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     1, 9));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     1, 9));
    vecs.push_back(v(0, 0, 0,   0,     0, 1, 0, 0,     0,     0, 9));

    // Reset state
    #12;
    chk("reset.count", int'(fifo_count), 0);
    chk("reset.codigo", int'(codigo), 0);
    chk("reset.entrada", int'(entrada), 0);
    chk("reset.result", int'(result), 0);
    chk("reset.rv", int'(result_valid), 0);
    chk("reset.ready", int'(cmd_if.cmd_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst              = vecs[i].rst;
      cmd_if.cmd_valid = vecs[i].valid;
      cmd_if.cmd_op    = vecs[i].op;
      cmd_if.cmd_data  = vecs[i].data;
      pause            = vecs[i].pause;
      step();
      chk($sformatf("row%0d.ready", i), int'(cmd_if.cmd_ready), int'(vecs[i].e_ready));
      chk($sformatf("row%0d.count", i), int'(fifo_count), int'(vecs[i].e_count));
      chk($sformatf("row%0d.codigo", i), int'(codigo), int'(vecs[i].e_codigo));
      chk($sformatf("row%0d.entrada", i), int'(entrada), int'(vecs[i].e_entrada));
      chk($sformatf("row%0d.rv", i), int'(result_valid), int'(vecs[i].e_rv));
      chk($sformatf("row%0d.result", i), int'(result), int'(vecs[i].e_result));
    end

    // Asynchronous reset takes effect between edges.
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = ADD; cmd_if.cmd_data = 8'h04;
    step();
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("async.pre_codigo", int'(codigo), int'(ADD));
    #2 rst = 1'b1;
    #1;
    chk("async.count", int'(fifo_count), 0);
    chk("async.codigo", int'(codigo), 0);
    chk("async.entrada", int'(entrada), 0);
    step();
    rst = 1'b0;

    // Full FIFO with valid held while popping: refused once, accepted next, nothing lost.
    sb_q.delete();
    sb_issued = 0;
    sb_en = 1'b1;
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 3'b100; cmd_if.cmd_data = 8'h10 + 8'(k);
      step();
    end
    chk("t5.full_count", int'(fifo_count), 4);
    pause = 1'b0;
    cmd_if.cmd_data = 8'h14;
    chk("t5.full_refuse", int'(cmd_if.cmd_ready), 0);
    step();
    chk("t5.pop_count", int'(fifo_count), 3);
    chk("t5.pop_entrada", int'(entrada), 8'h10);
    chk("t5.ready_again", int'(cmd_if.cmd_ready), 1);
    step();
    chk("t5.accept_count", int'(fifo_count), 3);
    chk("t5.accept_entrada", int'(entrada), 8'h11);
    cmd_if.cmd_data = 8'h15;
    step();
    chk("t5.third_entrada", int'(entrada), 8'h12);
    cmd_if.cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5.drain%0d", k), int'(entrada), 8'h13 + k);
    end
    chk("t5.empty", int'(fifo_count), 0);
    step();
    chk("t5.issued", sb_issued, 6);
    chk("t5.leftover", sb_q.size(), 0);
    sb_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
